// File: rtl/ctrl_pkg.sv
// Shared RV32I encoding definitions: descriptor enums, opcode/func constants, helpers.
// Shared by the instruction decoder and the instruction encoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8
  } cls_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } br_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } enc_t;

  // True when v is representable as a two's-complement number of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic [2:0] alu_func3(input logic [3:0] op);
    case (op)
      ALU_SLL:          return F3_SLL;
      ALU_SLT:          return F3_SLT;
      ALU_SLTU:         return F3_SLTU;
      ALU_XOR:          return F3_XOR;
      ALU_SRL, ALU_SRA: return F3_SRL_SRA;
      ALU_OR:           return F3_OR;
      ALU_AND:          return F3_AND;
      default:          return F3_ADD_SUB;
    endcase
  endfunction

  function automatic logic [2:0] br_func3(input logic [2:0] br);
    case (br)
      BR_BNE:  return F3_BNE;
      BR_BLT:  return F3_BLT;
      BR_BGE:  return F3_BGE;
      BR_BLTU: return F3_BLTU;
      BR_BGEU: return F3_BGEU;
      default: return F3_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small circular FIFO with occupancy count; pushes when full and pops when empty
// are dropped.
module enc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; emptiness is tracked by count alone, so stale
  // entries are never observable and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes RV32I descriptors into instruction words and streams (addr, word, err)
// through a small FIFO towards the instruction-memory load path.
module inst_encoder
  import ctrl_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_cls,
  input  logic [3:0]    in_alu_op,
  input  logic [2:0]    in_br_type,
  input  logic [2:0]    in_width,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [31:0]   out_inst,
  output logic          out_err,
  output logic          busy,
  output logic          done,
  output logic [15:0]   enc_count,
  output logic [15:0]   err_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = AW + 33;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr_q;
  enc_t          enc;
  logic          push;
  logic [FW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  function automatic enc_t encode(
    input logic [3:0] cls, input logic [3:0] alu_op, input logic [2:0] br_type,
    input logic [2:0] width, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [31:0] imm);
    enc_t       r;
    logic       ok;
    logic       is_shift;
    logic [6:0] f7;
    logic [2:0] f3;
    // NOTE: every result gets a default before the case so no path can hold a
    // previous value; this keeps the encoder purely combinational.
    r.word   = INST_NOP;
    ok       = 1'b0;
    f3       = alu_func3(alu_op);
    f7       = (alu_op == ALU_SUB || alu_op == ALU_SRA) ? F7_ALT : F7_BASE;
    is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
    case (cls)
      CLS_R: begin
        ok     = (alu_op <= ALU_AND);
        r.word = {f7, rs2, rs1, f3, rd, OPC_OP};
      end
      CLS_I_ALU: begin
        ok     = (alu_op <= ALU_AND) && (alu_op != ALU_SUB) &&
                 (is_shift ? (imm[31:5] == '0) : fits_signed(imm, 12));
        r.word = is_shift ? {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM}
                          : {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
      end
      CLS_LOAD: begin
        ok     = (width inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && fits_signed(imm, 12);
        r.word = {imm[11:0], rs1, width, rd, OPC_LOAD};
      end
      CLS_STORE: begin
        ok     = (width <= 3'd2) && fits_signed(imm, 12);
        r.word = {imm[11:5], rs2, rs1, width, imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        ok     = (br_type != 3'd0) && (br_type != 3'd7) && !imm[0] && fits_signed(imm, 13);
        r.word = {imm[12], imm[10:5], rs2, rs1, br_func3(br_type), imm[4:1], imm[11], OPC_BRANCH};
      end
      CLS_LUI, CLS_AUIPC: begin
        ok     = (imm[11:0] == '0);
        r.word = {imm[31:12], rd, (cls == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      CLS_JAL: begin
        ok     = !imm[0] && fits_signed(imm, 21);
        r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      CLS_JALR: begin
        ok     = fits_signed(imm, 12);
        r.word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) r.word = INST_NOP;
    r.err = !ok;
    return r;
  endfunction

  always_comb begin
    enc = encode(in_cls, in_alu_op, in_br_type, in_width, in_rd, in_rs1, in_rs2, in_imm);
  end

  assign in_ready  = (state == ST_RUN) && !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign busy      = (state != ST_IDLE);
  // Head fields read as zero while empty so nothing stale leaks after reset.
  assign {out_addr, out_inst, out_err} = fifo_empty ? '0 : fifo_rdata;

  enc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({addr_q, enc.word, enc.err}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      enc_count <= '0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_RUN;
          addr_q    <= base_addr;
          enc_count <= '0;
          err_count <= '0;
        end
        ST_RUN:   if (stop) state <= ST_DRAIN;
        ST_DRAIN: if (fifo_count == '0) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default:  state <= ST_IDLE;
      endcase
      // Accepts happen only in RUN, so they never collide with the IDLE load.
      if (push) begin
        addr_q <= addr_q + AW'(4);
        if (enc_count != 16'hFFFF) enc_count <= enc_count + 1'b1;
        if (enc.err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
